// File: rtl/calc_pkg.sv
// calc_pkg: shared FSM states, display digit codes and helper functions for the calculator
package calc_pkg;
  typedef enum logic [2:0] {ENTER_A, ENTER_B, CONVERT, SHOW, ERROR} state_e;
  localparam logic [3:0] MINUS = 4'hA;
  localparam logic [3:0] BLANK = 4'hB;
  localparam logic [3:0] ERR = 4'hE;
  function automatic logic [6:0] seg_encode(input logic [3:0] c);
    case (c)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      MINUS: return 7'h40;
      ERR: return 7'h79;
      default: return 7'h00;
    endcase
  endfunction
  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction
endpackage

// File: rtl/calc_bin2bcd_seq.sv
// bin2bcd_seq: iterative shift-add-3 binary to BCD converter, one bit per cycle
module bin2bcd_seq #(
  parameter int MW = 14,
  parameter int ND = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [MW-1:0]   bin,
  output logic            active,
  output logic            done,
  output logic [4*ND-1:0] bcd
);
  localparam int CW = $clog2(MW + 1);
  logic [MW-1:0] sh_q, sh_d;
  logic [4*ND-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0] cnt_q, cnt_d;
  logic active_q, active_d, step;
  // start performs the first shift directly from bin, so MW shifts finish one cycle before done
  always_comb begin
    step = start || (active_q && cnt_q != '0);
    adj = start ? '0 : bcd_q;
    for (int i = 0; i < ND; i++) adj[4*i +: 4] = adj[4*i +: 4] > 4'd4 ? adj[4*i +: 4] + 4'd3 : adj[4*i +: 4];
    {bcd_d, sh_d} = step ? {adj, start ? bin : sh_q} << 1 : {bcd_q, sh_q};
    cnt_d = start ? CW'(MW - 1) : step ? cnt_q - 1'b1 : cnt_q;
    active_d = step;
  end
  // Shift register, BCD accumulator and iteration counter
  always_ff @(posedge clk)
    if (!rst) begin
      sh_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      active_q <= 1'b0;
    end else begin
      sh_q <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      active_q <= active_d;
    end
  assign active = active_q;
  assign done = active_q && cnt_q == '0;
  assign bcd = bcd_q;
endmodule

// File: rtl/calc_param_top.sv
// calc_param_top: BCD two-operand add/subtract calculator driving a seven-segment display
module calc_param_top
  import calc_pkg::*;
#(
  parameter int ENTRY_DIGITS = 3,
  parameter int DISP_DIGITS = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     plus,
  input  logic                     minus,
  input  logic                     calc,
  input  logic [ENTRY_DIGITS-1:0]  digit_btn,
  output logic [7*DISP_DIGITS-1:0] seg,
  output logic                     busy,
  output logic                     neg,
  output logic                     ovf
);
  localparam int E = ENTRY_DIGITS;
  localparam int D = DISP_DIGITS;
  localparam int MW = $clog2(pow10(D - 1));
  localparam int AW = MW + 2;
  localparam int NB = E + 3;
  localparam logic [AW-1:0] LIMIT = AW'(pow10(D - 1) - 1);
  if (D < E + 2) begin : g_bad_digits
    $error("DISP_DIGITS must be at least ENTRY_DIGITS+2");
  end
  function automatic logic [AW-1:0] to_bin(input logic [4*E-1:0] v);
    logic [AW-1:0] r;
    r = '0;
    for (int i = E - 1; i >= 0; i--) r = r * AW'(10) + AW'(v[4*i +: 4]);
    return r;
  endfunction
  function automatic logic [4*E-1:0] bump(input logic [4*E-1:0] v, input logic [E-1:0] oh);
    logic [4*E-1:0] r;
    r = v;
    for (int i = 0; i < E; i++) if (oh[i]) r[4*i +: 4] = v[4*i +: 4] == 4'd9 ? 4'd0 : v[4*i +: 4] + 4'd1;
    return r;
  endfunction
  logic [NB-1:0] s1_q, s2_q, s3_q, ev;
  logic [E-1:0] dig_oh;
  logic is_calc, is_op, is_dig, op_minus;
  state_e state_q, state_d;
  logic [4*E-1:0] a_q, a_d, b_q, b_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] mag;
  logic op_q, op_d, ovf_q, ovf_d, neg_q, neg_d;
  logic [4*D-1:0] hold_q, codes;
  logic cv_active, cv_done;
  logic [4*(D-1)-1:0] cv_bcd;
  // Two-flop synchronizer plus one delayed copy for rising-edge detection
  always_ff @(posedge clk)
    if (!rst) {s1_q, s2_q, s3_q} <= '0;
    else {s1_q, s2_q, s3_q} <= {{digit_btn, minus, plus, calc}, s1_q, s2_q};
  assign ev = s2_q & ~s3_q;
  assign dig_oh = ev[NB-1:3] & -ev[NB-1:3];
  assign is_calc = ev[0];
  assign is_op = ~ev[0] & (ev[1] | ev[2]);
  assign op_minus = ~ev[1];
  assign is_dig = (~|ev[2:0]) & (|dig_oh);
  assign mag = acc_q[AW-1] ? -acc_q : acc_q;
  // Next-state and datapath updates; one prioritized event per cycle
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    op_d = op_q;
    ovf_d = ovf_q;
    neg_d = neg_q;
    case (state_q)
      ENTER_A:
        if (is_op) begin
          op_d = op_minus;
          acc_d = to_bin(a_q);
          b_d = '0;
          state_d = ENTER_B;
        end else if (is_dig) a_d = bump(a_q, dig_oh);
      ENTER_B:
        if (is_calc) begin
          acc_d = op_q ? acc_q - to_bin(b_q) : acc_q + to_bin(b_q);
          state_d = CONVERT;
        end else if (is_op) op_d = op_minus;
        else if (is_dig) b_d = bump(b_q, dig_oh);
      CONVERT:
        if (cv_done) begin
          state_d = mag > LIMIT ? ERROR : SHOW;
          ovf_d = mag > LIMIT;
          neg_d = mag > LIMIT ? neg_q : acc_q[AW-1];
        end
      default:
        if (is_dig) begin
          a_d = bump('0, dig_oh);
          ovf_d = 1'b0;
          neg_d = 1'b0;
          state_d = ENTER_A;
        end else if (is_op && state_q == SHOW) begin
          op_d = op_minus;
          b_d = '0;
          state_d = ENTER_B;
        end
    endcase
  end
  // FSM state, operands, accumulator and the display snapshot frozen during conversion
  always_ff @(posedge clk)
    if (!rst) begin
      state_q <= ENTER_A;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      op_q <= 1'b0;
      ovf_q <= 1'b0;
      neg_q <= 1'b0;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      op_q <= op_d;
      ovf_q <= ovf_d;
      neg_q <= neg_d;
      hold_q <= codes;
    end
  bin2bcd_seq #(.MW(MW), .ND(D - 1)) u_b2b (
    .clk(clk),
    .rst(rst),
    .start(state_q == CONVERT && !cv_active),
    .bin(mag[MW-1:0]),
    .active(cv_active),
    .done(cv_done),
    .bcd(cv_bcd)
  );
  assign codes = state_q == CONVERT ? hold_q
               : state_q == ERROR ? {D{ERR}}
               : state_q == SHOW ? {neg_q ? MINUS : BLANK, cv_bcd}
               : {{(D - E){BLANK}}, state_q == ENTER_A ? a_q : b_q};
  for (genvar k = 0; k < D; k++) begin : g_seg
    assign seg[7*k +: 7] = seg_encode(codes[4*k +: 4]);
  end
  assign busy = state_q == CONVERT;
  assign neg = neg_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_calc_param_top.sv
// tb_calc_param_top: directed and randomized checks of calc_param_top against a behavioural model
module tb_calc_param_top;
  localparam int E = 3;
  localparam int D = 5;
  localparam int EA = 0, EB = 1, CV = 2, SH = 3, ER = 4;
  localparam logic [5:0] C = 6'b000001, P = 6'b000010, M = 6'b000100, D0 = 6'b001000;
  localparam logic [34:0] RESET_SEG = {7'h00, 7'h00, 7'h3F, 7'h3F, 7'h3F};
  logic clk = 1'b0, rst = 1'b0, plus = 1'b0, minus = 1'b0, calc = 1'b0;
  logic [E-1:0] digit_btn = '0;
  logic [7*D-1:0] seg;
  logic busy, neg, ovf;
  int n_checks = 0, n_fail = 0;
  int m_mode, m_a, m_b, m_acc, m_op, m_neg, m_ovf, busy_len;
  logic [7*D-1:0] m_prev;

  calc_param_top #(.ENTRY_DIGITS(E), .DISP_DIGITS(D)) dut (
    .clk(clk), .rst(rst), .plus(plus), .minus(minus), .calc(calc),
    .digit_btn(digit_btn), .seg(seg), .busy(busy), .neg(neg), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic int p10(input int n);
    int r;
    r = 1;
    repeat (n) r = r * 10;
    return r;
  endfunction
  function automatic int dig(input int v, input int k);
    return (v / p10(k)) % 10;
  endfunction
  function automatic int bump(input int v, input int k);
    return v + ((dig(v, k) + 1) % 10 - dig(v, k)) * p10(k);
  endfunction
  function automatic logic [6:0] glyph(input int c);
    case (c)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      10: return 7'h40;
      14: return 7'h79;
      default: return 7'h00;
    endcase
  endfunction
  function automatic logic [7*D-1:0] exp_seg();
    logic [7*D-1:0] r;
    int mag, c;
    r = '0;
    mag = m_acc < 0 ? -m_acc : m_acc;
    for (int k = 0; k < D; k++) begin
      case (m_mode)
        EA: c = k < E ? dig(m_a, k) : 11;
        EB: c = k < E ? dig(m_b, k) : 11;
        SH: c = k < D - 1 ? dig(mag, k) : (m_neg != 0 ? 10 : 11);
        default: c = 14;
      endcase
      r[7*k +: 7] = glyph(c);
    end
    return m_mode == CV ? m_prev : r;
  endfunction
  function automatic void model_reset();
    m_mode = EA; m_a = 0; m_b = 0; m_acc = 0; m_op = 0; m_neg = 0; m_ovf = 0;
  endfunction
  function automatic void model_press(input logic [5:0] mask);
    int kind, idx;
    kind = -1;
    idx = 0;
    if (mask[0]) kind = 0;
    else if (mask[1]) kind = 1;
    else if (mask[2]) kind = 2;
    else for (int i = E - 1; i >= 0; i--) if (mask[3+i]) begin kind = 3; idx = i; end
    case (m_mode)
      EA:
        if (kind == 3) m_a = bump(m_a, idx);
        else if (kind == 1 || kind == 2) begin m_op = kind - 1; m_acc = m_a; m_b = 0; m_mode = EB; end
      EB:
        if (kind == 3) m_b = bump(m_b, idx);
        else if (kind == 1 || kind == 2) m_op = kind - 1;
        else if (kind == 0) begin
          m_prev = exp_seg();
          m_acc = m_op != 0 ? m_acc - m_b : m_acc + m_b;
          m_mode = CV;
        end
      SH, ER:
        if (kind == 3) begin m_a = bump(0, idx); m_ovf = 0; m_neg = 0; m_mode = EA; end
        else if (m_mode == SH && (kind == 1 || kind == 2)) begin m_op = kind - 1; m_b = 0; m_mode = EB; end
      default: ;
    endcase
  endfunction
  function automatic void model_done();
    int mag;
    mag = m_acc < 0 ? -m_acc : m_acc;
    if (mag > p10(D - 1) - 1) begin m_mode = ER; m_ovf = 1; end
    else begin m_mode = SH; m_neg = m_acc < 0 ? 1 : 0; end
  endfunction

  task automatic do_reset();
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    model_reset();
  endtask
  task automatic wait_conv();
    int t;
    t = 0;
    busy_len = 0;
    while (!busy && t < 20) begin @(negedge clk); t++; end
    while (busy && busy_len < 100) begin @(negedge clk); busy_len++; end
    n_checks++;
    if (busy_len == 0 || busy) begin
      n_fail++;
      $display("FAIL conv_timeout busy_len=%0d busy=%b", busy_len, busy);
    end
    model_done();
    repeat (2) @(negedge clk);
  endtask
  task automatic press(input logic [5:0] mask);
    @(negedge clk) {digit_btn, minus, plus, calc} = mask;
    model_press(mask);
    repeat (2) @(negedge clk);
    {digit_btn, minus, plus, calc} = '0;
    if (m_mode == CV) wait_conv();
    else repeat (4) @(negedge clk);
  endtask
  task automatic press_n(input logic [5:0] mask, input int n);
    repeat (n) press(mask);
  endtask
  task automatic enter(input int v);
    for (int i = 0; i < E; i++) press_n(6'(D0 << i), dig(v, i));
  endtask
  task automatic start_calc_manual();
    int t;
    @(negedge clk) calc = 1'b1;
    model_press(C);
    repeat (2) @(negedge clk);
    calc = 1'b0;
    t = 0;
    while (!busy && t < 20) begin @(negedge clk); t++; end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (seg !== RESET_SEG) begin n_fail++; $display("FAIL reset_seg got=%h exp=%h", seg, RESET_SEG); end
    n_checks++;
    if ({busy, ovf, neg} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got busy/ovf/neg=%b%b%b exp=000", busy, ovf, neg); end
  endtask
  task automatic test_entry();
    logic [34:0] exp;
    exp = {7'h00, 7'h00, 7'h5B, 7'h4F, 7'h06};
    do_reset();
    press_n(6'b100000, 2);
    press_n(6'b010000, 3);
    press_n(D0, 11);
    n_checks++;
    if (seg !== exp) begin n_fail++; $display("FAIL entry_231 got=%h exp=%h", seg, exp); end
    n_checks++;
    if (seg !== exp_seg()) begin n_fail++; $display("FAIL entry_model got=%h exp=%h", seg, exp_seg()); end
  endtask
  task automatic test_add();
    logic [34:0] exp;
    exp = {7'h00, 7'h3F, 7'h06, 7'h7D, 7'h7F};
    do_reset();
    enter(123);
    press(P);
    enter(45);
    press(C);
    n_checks++;
    if (busy_len != 15) begin n_fail++; $display("FAIL add_busy_len got=%0d exp=15", busy_len); end
    n_checks++;
    if (seg !== exp) begin n_fail++; $display("FAIL add_seg got=%h exp=%h", seg, exp); end
    n_checks++;
    if (neg !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL add_flags got neg=%b ovf=%b exp 0 0", neg, ovf); end
  endtask
  task automatic test_sub();
    logic [34:0] exp;
    exp = {7'h40, 7'h3F, 7'h4F, 7'h4F, 7'h4F};
    do_reset();
    enter(12);
    press(M);
    enter(345);
    press(C);
    n_checks++;
    if (seg !== exp) begin n_fail++; $display("FAIL sub_seg got=%h exp=%h", seg, exp); end
    n_checks++;
    if (neg !== 1'b1) begin n_fail++; $display("FAIL sub_neg got=%b exp=1", neg); end
  endtask
  task automatic test_overflow();
    logic [34:0] exp;
    do_reset();
    enter(999);
    for (int i = 0; i < 10; i++) begin
      press(P);
      enter(999);
      press(C);
      n_checks++;
      if (seg !== exp_seg() || ovf !== m_ovf[0]) begin
        n_fail++;
        $display("FAIL chain_%0d got seg=%h ovf=%b exp seg=%h ovf=%0d", i, seg, ovf, exp_seg(), m_ovf);
      end
    end
    exp = {5{7'h79}};
    n_checks++;
    if (seg !== exp || ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_error got seg=%h ovf=%b exp seg=%h ovf=1", seg, ovf, exp); end
    press(D0);
    exp = {7'h00, 7'h00, 7'h3F, 7'h3F, 7'h06};
    n_checks++;
    if (seg !== exp || ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_recover got seg=%h ovf=%b exp seg=%h ovf=0", seg, ovf, exp); end
  endtask
  task automatic test_back_to_back();
    logic [34:0] exp;
    do_reset();
    enter(5);
    press(P);
    enter(7);
    press(C | P);
    exp = {7'h00, 7'h3F, 7'h3F, 7'h06, 7'h5B};
    n_checks++;
    if (seg !== exp) begin n_fail++; $display("FAIL prio_calc_plus got=%h exp=%h", seg, exp); end
    press(P);
    press(D0);
    start_calc_manual();
    @(negedge clk) digit_btn[0] = 1'b1;
    repeat (2) @(negedge clk);
    digit_btn[0] = 1'b0;
    wait_conv();
    exp = {7'h00, 7'h3F, 7'h3F, 7'h06, 7'h4F};
    n_checks++;
    if (seg !== exp) begin n_fail++; $display("FAIL busy_drop got=%h exp=%h", seg, exp); end
    press(P);
    press(D0);
    start_calc_manual();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    model_reset();
    n_checks++;
    if (seg !== RESET_SEG || busy !== 1'b0) begin n_fail++; $display("FAIL abort_reset got seg=%h busy=%b exp seg=%h busy=0", seg, busy, RESET_SEG); end
    repeat (30) @(negedge clk);
    n_checks++;
    if (seg !== exp_seg() || busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle got seg=%h busy=%b exp seg=%h busy=0", seg, busy, exp_seg()); end
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 80; i++) begin
      logic [5:0] mask;
      int r;
      r = $urandom_range(0, 9);
      mask = r < 2 ? C : r < 3 ? P : r < 4 ? M : r < 5 ? 6'($urandom_range(1, 63)) : 6'(D0 << $urandom_range(0, 2));
      press(mask);
      n_checks++;
      if (seg !== exp_seg() || neg !== m_neg[0] || ovf !== m_ovf[0] || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL random_%0d mask=%b got seg=%h neg=%b ovf=%b busy=%b exp seg=%h neg=%0d ovf=%0d busy=0",
                 i, mask, seg, neg, ovf, busy, exp_seg(), m_neg, m_ovf);
      end
    end
  endtask

  initial begin
    model_reset();
    m_prev = '0;
    busy_len = 0;
    test_reset();
    test_entry();
    test_add();
    test_sub();
    test_overflow();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/calc_param_top.md
CALC_PARAM_TOP -- requirements
Module: calc_param_top

Interface
REQ-001 Parameter ENTRY_DIGITS, default 3, number of BCD operand digits the user can edit.
REQ-002 Parameter DISP_DIGITS, default 5, number of seven-segment digits driven; SHALL be >= ENTRY_DIGITS+2 (elaboration error otherwise).
REQ-003 Derived constant MW: the minimum bits needed to hold 10^(DISP_DIGITS-1)-1 (14 at defaults).
REQ-004 Port clk, input, 1, sole clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1, synchronous active-low reset.
REQ-006 Port plus, input, 1, asynchronous level button selecting addition.
REQ-007 Port minus, input, 1, asynchronous level button selecting subtraction.
REQ-008 Port calc, input, 1, asynchronous level button that executes the pending operation.
REQ-009 Port digit_btn, input, ENTRY_DIGITS, asynchronous level buttons; bit i increments operand digit i (bit 0 is the ones digit).
REQ-010 Port seg, output, 7*DISP_DIGITS, segment patterns; digit k occupies seg[7k+6:7k]; digit 0 is the least significant.
REQ-011 Port busy, output, 1, high while a result conversion is in progress.
REQ-012 Port neg, output, 1, the displayed result is negative.
REQ-013 Port ovf, output, 1, the last result exceeded the display range.

Function
REQ-014 Each button SHALL pass through a 2-FF synchronizer followed by a rising-edge detector; a press becomes an event exactly one clk cycle wide, 3 cycles after the input rises.
REQ-015 At most one event SHALL be processed per cycle, with priority calc > plus > minus > digit_btn (lowest index first); lower-priority events in that cycle are dropped.
REQ-016 FSM states: ENTER_A, ENTER_B, CONVERT, SHOW, ERROR.
REQ-017 In ENTER_A, a digit event on bit i SHALL increment A digit i modulo 10, with no carry (9 becomes 0).
REQ-018 In ENTER_A, a plus or minus event SHALL latch the op, convert A to binary into the signed accumulator ACC (MW+2 bits), clear B, and move to ENTER_B.
REQ-019 In ENTER_A, a calc event SHALL be ignored.
REQ-020 In ENTER_B, digit events SHALL edit B in the same way as A.
REQ-021 In ENTER_B, plus or minus SHALL replace the latched op and stay in ENTER_B.
REQ-022 In ENTER_B, calc SHALL compute ACC = ACC ± B and move to CONVERT.
REQ-023 In CONVERT, the magnitude |ACC| SHALL be loaded into bin2bcd_seq and busy asserted; conversion takes exactly MW+1 cycles; all events are dropped; seg holds its previous contents.
REQ-024 On conversion done, if |ACC| > 10^(DISP_DIGITS-1)-1 the FSM SHALL go to ERROR; otherwise it SHALL go to SHOW.
REQ-025 In ERROR, ovf=1 and every digit SHALL show 'E'.
REQ-026 In SHOW, a plus or minus event SHALL latch the op, keep ACC, clear B, and move to ENTER_B (chaining).
REQ-027 In SHOW or ERROR, a digit event SHALL clear A, apply the increment, clear ovf and neg, and move to ENTER_A.
REQ-028 In ERROR, plus, minus and calc events SHALL be ignored.
REQ-029 Display in ENTER_A and ENTER_B: the operand being edited (A or B) is shown, zero-padded, in digits 0..ENTRY_DIGITS-1; higher digits are blank.
REQ-030 Display in SHOW: DISP_DIGITS-1 magnitude digits, zero-padded, in digits 0..DISP_DIGITS-2; the top digit shows '-' if neg, blank otherwise.
REQ-031 neg SHALL be set to the sign of ACC on entry to SHOW.
REQ-032 Segment code is {g,f,e,d,c,b,a}, with 1 = lit.

Reset
REQ-033 While rst=0 at a clk edge, the block SHALL enter ENTER_A with A=B=ACC=0, op=plus, busy=ovf=neg=0, synchronizers cleared, and any conversion aborted.
REQ-034 The first cycle after reset SHALL show digits 0..ENTRY_DIGITS-1 as '0' and the rest blank.

Structure
REQ-035 Package calc_pkg SHALL hold: the FSM state enum; digit codes (0-9, MINUS=4'hA, BLANK=4'hB, ERR=4'hE); the seg_encode function; and a pow10 constant function.
REQ-036 One sub-module, bin2bcd_seq, SHALL implement iterative shift-add-3 conversion with start/done and MW-bit input.
REQ-037 Per-digit encoding SHALL be a generate loop over seg_encode.

Verification (defaults)
REQ-038 Reset: rst=0 for 1 cycle -> seg shows blank, blank, 0, 0, 0; busy=ovf=neg=0.
REQ-039 Digit entry: digit_btn[2] x2, [1] x3, [0] x11 -> display 231 (ones digit wraps).
REQ-040 Addition: A=123, plus, B=45, calc -> busy high exactly 15 cycles -> display blank, 0, 1, 6, 8 with neg=0.
REQ-041 Subtraction: A=12, minus, B=345, calc -> display '-', 0, 3, 3, 3 with neg=1.
REQ-042 Overflow: A=999, then chain (plus, B=999, calc) 10 times -> the 10th result 10989 gives ERROR, ovf=1, all 'E'; a later digit_btn[0] press -> display 001 and ovf=0.
REQ-043 Priority and abort: calc and plus in the same cycle in ENTER_B -> calc wins; a press during busy is dropped; rst=0 mid-CONVERT -> reset display on the next cycle.
